wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 92 +++++++++
 tb/tb_wide_add_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Sequential wide adder: latches an N-bit operand pair, then ripples one W-bit
// slice per cycle through a registered carry, presenting {cout,sum} in DONE.
module wide_add_seq #(
  parameter int W      = 32,
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W*NWORDS-1:0]   a,
  input  logic [W*NWORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W*NWORDS-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int N  = W * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    a_q, b_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [W-1:0]    slice_sum;
  logic            slice_c;

  // One slice of the ripple: the only adder in the design.
  always_comb begin
    {slice_c, slice_sum} = {1'b0, a_q[idx*W +: W]} + {1'b0, b_q[idx*W +: W]}
                           + (W+1)'(carry);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[idx*W +: W] <= slice_sum;
          carry           <= slice_c;
          if (idx == LAST) cout <= slice_c;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: the driver pushes the arithmetic reference
// result on every accept, an independent monitor pops and compares on handshakes.
module tb_wide_add_seq;

  localparam int W      = 32;
  localparam int NWORDS = 4;
  localparam int N      = W * NWORDS;
  localparam int NRAND  = 3000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [N-1:0] a, b, sum;

  wide_add_seq #(.W(W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  logic [N:0] exp_q[$];
  int         acc_q[$];
  int         hold_mode = 0;   // <0: random stalls, else fixed stall length
  int         last_acc = 0;

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] x = '0;
    case ($urandom_range(0, 9))
      0: x = '1;
      1: x = '0;
      default:
        for (int i = 0; i < (N + 31) / 32; i++) x = (x << 32) | N'($urandom);
    endcase
    return x;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge
  // with in_valid still high.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    int n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    #1;
    while (!in_ready) begin
      @(negedge clk);
      #1;
      if (++n > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        return;
      end
    end
    exp_q.push_back({1'b0, av} + {1'b0, bv});
    acc_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(negedge clk);
  endtask

  // Monitor: drives out_ready and checks every DONE cycle against the queue head.
  initial begin
    bit lat_done = 0;
    int hold_cnt = 0;
    int hold_target = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        out_ready = 1'b1;
        lat_done  = 0;
        hold_cnt  = 0;
      end else if (out_valid) begin
        if (!lat_done) begin
          lat_done = 1;
          hold_cnt = 0;
          if (hold_mode < 0)
            hold_target = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
          else
            hold_target = hold_mode;
          if (acc_q.size() > 0) chk("latency", (N+1)'(cyc - acc_q.pop_front()), (N+1)'(NWORDS));
        end
        if (hold_cnt < hold_target) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0h expected none", {cout, sum});
        end else begin
          chk("result", {cout, sum}, exp_q[0]);
          chk("in_ready_done", (N+1)'(in_ready), '0);
          chk("busy_done", (N+1)'(busy), 1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            lat_done = 0;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    int p;
    logic [N-1:0] top;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    top = '0;
    top[N-1] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_in_ready", (N+1)'(in_ready), 1);
    chk("rst_out_valid", (N+1)'(out_valid), 0);
    chk("rst_busy", (N+1)'(busy), 0);
    chk("rst_sum_cout", {cout, sum}, '0);
    @(negedge clk);

    // Full ripple, cross-slice carry.
    hold_mode = 0;
    issue('1, N'(1));
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    issue({32'h0, {(N-32){1'b1}}}, N'(1));
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Backpressure with a competing in_valid held high throughout.
    hold_mode = 5;
    issue(rnd_op(), rnd_op());
    p = last_acc;
    issue(rnd_op(), rnd_op());
    hold_mode = 0;
    in_valid = 1'b0;
    chk("stall_interval", (N+1)'(last_acc - p), (N+1)'(NWORDS + 2 + 5));
    repeat (8) @(negedge clk);

    // Reset asserted on the second RUN edge.
    issue(rnd_op(), rnd_op());
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_in_ready", (N+1)'(in_ready), 1);
    chk("midrst_out_valid", (N+1)'(out_valid), 0);
    chk("midrst_sum_cout", {cout, sum}, '0);
    repeat (10) @(negedge clk);

    // Back-to-back accepts.
    issue(N'(5), N'(3));
    p = last_acc;
    issue(top, top);
    in_valid = 1'b0;
    chk("b2b_interval", (N+1)'(last_acc - p), (N+1)'(NWORDS + 2));
    repeat (8) @(negedge clk);

    // Random traffic with random input gaps and output stalls.
    hold_mode = -1;
    for (int i = 0; i < NRAND; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      issue(rnd_op(), rnd_op());
    end
    in_valid = 1'b0;

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
